// File: rtl/snitch_dma_req_queue.sv
// snitch_dma_req_queue
// Buffers 1D DMA requests from the Xdma offload port, hands out in-order
// transfer IDs, forwards requests to the DMA backend and tracks completions
// so software can poll the most recently retired ID.
// Optional feature macro: DMA_REQ_QUEUE_PERF_EN adds stall and issued-byte
// counters (stall_cycles_o, issued_bytes_o); functional behaviour is unchanged.
//
// Handshake: a transfer on req_* happens when req_valid_i & req_ready_o, and on
// be_* when be_valid_o & be_ready_i; once be_valid_o is high the be_* payload is
// held until be_ready_i. Neither ready depends combinationally on its own valid.
module snitch_dma_req_queue #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned LenWidth    = 32,
    parameter int unsigned IdWidth     = 32,
    parameter int unsigned Depth       = 3,
    parameter int unsigned MaxInflight = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_src_i,
    input  logic [AddrWidth-1:0] req_dst_i,
    input  logic [LenWidth-1:0]  req_len_i,
    output logic [IdWidth-1:0]   req_tid_o,
    output logic                 be_valid_o,
    input  logic                 be_ready_i,
    output logic [AddrWidth-1:0] be_src_o,
    output logic [AddrWidth-1:0] be_dst_o,
    output logic [LenWidth-1:0]  be_len_o,
    output logic [IdWidth-1:0]   be_tid_o,
    input  logic                 be_done_i,
    output logic [IdWidth-1:0]   last_done_tid_o,
    output logic                 busy_o
`ifdef DMA_REQ_QUEUE_PERF_EN
    ,
    output logic [31:0]          stall_cycles_o,
    output logic [63:0]          issued_bytes_o
`endif
);

    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam int unsigned RingW = (MaxInflight > 1) ? $clog2(MaxInflight) : 1;
    localparam int unsigned InfW  = $clog2(MaxInflight + 1);

    // Request FIFO storage and bookkeeping
    logic [AddrWidth-1:0] src_mem [Depth];
    logic [AddrWidth-1:0] dst_mem [Depth];
    logic [LenWidth-1:0]  len_mem [Depth];
    logic [IdWidth-1:0]   tid_mem [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;

    // IDs of transfers issued to the backend, oldest at ring_rd_q
    logic [IdWidth-1:0]   ring_mem [MaxInflight];
    logic [RingW-1:0]     ring_wr_q, ring_rd_q;
    logic [InfW-1:0]      inflight_q;

    logic [IdWidth-1:0]   next_tid_q;
    logic [IdWidth-1:0]   last_done_q;

    logic empty, full, head_zero, accept, issue, zero_retire, pop, done;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    function automatic logic [RingW-1:0] ring_inc(input logic [RingW-1:0] p);
        return (p == RingW'(MaxInflight - 1)) ? '0 : p + RingW'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(Depth));
    assign head_zero = !empty && (len_mem[rd_ptr_q] == '0);

    // Readiness deliberately ignores a same-cycle pop: a full queue refuses pushes.
    assign req_ready_o = !full;
    assign req_tid_o   = next_tid_q;
    assign accept      = req_valid_i && req_ready_o;

    // Zero-length heads are never offered; they retire once nothing is in flight,
    // which keeps retirement strictly in ID order.
    assign be_valid_o  = !empty && !head_zero && (inflight_q < InfW'(MaxInflight));
    assign issue       = be_valid_o && be_ready_i;
    assign zero_retire = head_zero && (inflight_q == '0);
    assign pop         = issue || zero_retire;
    assign done        = be_done_i && (inflight_q != '0);

    assign be_src_o = empty ? '0 : src_mem[rd_ptr_q];
    assign be_dst_o = empty ? '0 : dst_mem[rd_ptr_q];
    assign be_len_o = empty ? '0 : len_mem[rd_ptr_q];
    assign be_tid_o = empty ? '0 : tid_mem[rd_ptr_q];

    assign last_done_tid_o = last_done_q;
    assign busy_o          = !empty || (inflight_q != '0);

    // FIFO payload write; contents are only observed while the entry is occupied
    always_ff @(posedge clk_i) begin
        if (accept) begin
            src_mem[wr_ptr_q] <= req_src_i;
            dst_mem[wr_ptr_q] <= req_dst_i;
            len_mem[wr_ptr_q] <= req_len_i;
            tid_mem[wr_ptr_q] <= next_tid_q;
        end
    end

    // Issued-ID ring write; an entry is read back when its completion arrives
    always_ff @(posedge clk_i) begin
        if (issue) begin
            ring_mem[ring_wr_q] <= tid_mem[rd_ptr_q];
        end
    end

    // FIFO pointers, occupancy and ID allocation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            next_tid_q <= IdWidth'(1);
        end else begin
            if (accept) begin
                wr_ptr_q   <= ptr_inc(wr_ptr_q);
                next_tid_q <= next_tid_q + IdWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (accept && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!accept && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // In-flight tracking and retirement of completed / zero-length transfers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ring_wr_q   <= '0;
            ring_rd_q   <= '0;
            inflight_q  <= '0;
            last_done_q <= '0;
        end else begin
            if (issue) begin
                ring_wr_q <= ring_inc(ring_wr_q);
            end
            if (done) begin
                ring_rd_q   <= ring_inc(ring_rd_q);
                last_done_q <= ring_mem[ring_rd_q];
            end else if (zero_retire) begin
                last_done_q <= tid_mem[rd_ptr_q];
            end
            if (issue && !done) begin
                inflight_q <= inflight_q + InfW'(1);
            end else if (!issue && done) begin
                inflight_q <= inflight_q - InfW'(1);
            end
        end
    end

`ifdef DMA_REQ_QUEUE_PERF_EN
    logic [64:0] bytes_sum;
    assign bytes_sum = {1'b0, issued_bytes_o} + 65'(be_len_o);

    // Saturating stall-cycle and issued-byte counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_o <= '0;
            issued_bytes_o <= '0;
        end else begin
            if (req_valid_i && !req_ready_o && (stall_cycles_o != '1)) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
            if (issue) begin
                issued_bytes_o <= bytes_sum[64] ? '1 : bytes_sum[63:0];
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // A completion with nothing in flight is a protocol error of the backend
    done_needs_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
        be_done_i |-> (inflight_q != '0));
`endif

endmodule

// File: tb/tb_snitch_dma_req_queue.sv
// Testbench for snitch_dma_req_queue: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_snitch_dma_req_queue;

    localparam int AW    = 64;
    localparam int LW    = 32;
    localparam int IW    = 4;   // narrow IDs so wrap-around occurs often
    localparam int DEPTH = 3;
    localparam int MAXI  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_ready;
    logic [AW-1:0] req_src, req_dst;
    logic [LW-1:0] req_len;
    logic [IW-1:0] req_tid;
    logic          be_valid, be_ready;
    logic [AW-1:0] be_src, be_dst;
    logic [LW-1:0] be_len;
    logic [IW-1:0] be_tid;
    logic          be_done;
    logic [IW-1:0] last_done;
    logic          busy;

    snitch_dma_req_queue #(
        .AddrWidth(AW), .LenWidth(LW), .IdWidth(IW), .Depth(DEPTH), .MaxInflight(MAXI)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_src_i(req_src), .req_dst_i(req_dst), .req_len_i(req_len),
        .req_tid_o(req_tid),
        .be_valid_o(be_valid), .be_ready_i(be_ready),
        .be_src_o(be_src), .be_dst_o(be_dst), .be_len_o(be_len), .be_tid_o(be_tid),
        .be_done_i(be_done), .last_done_tid_o(last_done), .busy_o(busy)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [LW-1:0] len;
        logic [IW-1:0] tid;
    } req_t;

    req_t          pend_q[$];   // accepted, not yet issued/retired
    logic [IW-1:0] infl_q[$];   // issued IDs, oldest first
    logic [IW-1:0] m_next_tid;
    logic [IW-1:0] m_last_done;
    logic          m_acc;
    logic [IW-1:0] obs_tid;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        pend_q.delete();
        infl_q.delete();
        m_next_tid  = IW'(1);
        m_last_done = '0;
    endtask

    // ---------------- driver: one clock cycle with model check ----------------
    task automatic step(input logic v, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [LW-1:0] l, input logic br, input logic dn);
        logic e_ready, e_bv, e_zret, e_issue, e_done;
        req_t head;
        @(negedge clk);
        req_valid = v; req_src = s; req_dst = d; req_len = l;
        be_ready = br; be_done = dn;
        #1;
        head    = (pend_q.size() > 0) ? pend_q[0] : '0;
        e_ready = pend_q.size() < DEPTH;
        e_bv    = (pend_q.size() > 0) && (head.len != 0) && (infl_q.size() < MAXI);
        e_zret  = (pend_q.size() > 0) && (head.len == 0) && (infl_q.size() == 0);
        check("req_ready", req_ready, e_ready);
        check("req_tid", req_tid, m_next_tid);
        check("be_valid", be_valid, e_bv);
        check("be_src", be_src, head.src);
        check("be_dst", be_dst, head.dst);
        check("be_len", be_len, head.len);
        check("be_tid", be_tid, head.tid);
        check("last_done", last_done, m_last_done);
        check("busy", busy, (pend_q.size() > 0) || (infl_q.size() > 0));
        obs_tid = req_tid;
        @(posedge clk);
        m_acc   = v && e_ready;
        e_issue = e_bv && br;
        e_done  = dn && (infl_q.size() > 0);
        if (e_done) m_last_done = infl_q.pop_front();
        if (e_issue) infl_q.push_back(head.tid);
        if (e_zret) m_last_done = head.tid;
        if (e_issue || e_zret) void'(pend_q.pop_front());
        if (m_acc) begin
            pend_q.push_back('{src: s, dst: d, len: l, tid: m_next_tid});
            m_next_tid = m_next_tid + IW'(1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (pend_q.size() > 0 || infl_q.size() > 0); i++)
            step(1'b0, '0, '0, '0, 1'b1, infl_q.size() > 0);
        check("drain_model_empty", 64'(pend_q.size() + infl_q.size()), 64'd0);
        #1;
        check("drain_busy", busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 1'b1);
        check({tag, "_tid"}, req_tid, IW'(1));
        check({tag, "_bev"}, be_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_last"}, last_done, '0);
        check({tag, "_src"}, be_src, '0);
        check({tag, "_len"}, be_len, '0);
        check({tag, "_betid"}, be_tid, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [IW-1:0] base;
        int acc_cnt;
        req_valid = 0; req_src = '0; req_dst = '0; req_len = '0;
        be_ready = 0; be_done = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single request end to end
        step(1'b1, 64'h1000, 64'h2000, 32'd64, 1'b0, 1'b0);
        check("t1_tid", obs_tid, IW'(1));
        #1;
        check("t1_bev", be_valid, 1'b1);
        check("t1_src", be_src, 64'h1000);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        #1;
        check("t1_last", last_done, IW'(1));
        check("t1_busy", busy, 1'b0);

        // backpressure: full queue refuses a push even while popping
        for (int i = 0; i < 4; i++)
            step(1'b1, 64'(i) << 12, 64'(i) << 16, 32'd16 + 32'(i), 1'b0, 1'b0);
        #1;
        check("t2_full", req_ready, 1'b0);
        step(1'b1, 64'h33, 64'h44, 32'd8, 1'b1, 1'b0);
        check("t2_pop_no_acc", 64'(m_acc), 64'd0);
        step(1'b1, 64'h33, 64'h44, 32'd8, 1'b0, 1'b0);
        check("t2_acc", 64'(m_acc), 64'd1);
        drain();

        // in-flight limit
        acc_cnt = 0;
        for (int i = 0; i < 20 && acc_cnt < 5; i++) begin
            step(1'b1, 64'(i), 64'(i + 100), 32'd4, 1'b1, 1'b0);
            if (m_acc) acc_cnt++;
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        #1;
        check("t3_hold", be_valid, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        #1;
        check("t3_release", be_valid, 1'b1);
        drain();

        // zero-length request waits behind in-flight transfers
        base = m_next_tid;
        step(1'b1, 64'hA0, 64'hB0, 32'd64, 1'b1, 1'b0);
        step(1'b1, 64'hA1, 64'hB1, 32'd64, 1'b1, 1'b0);
        step(1'b1, 64'hA2, 64'hB2, 32'd0, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        #1;
        check("t4_zero_held", be_valid, 1'b0);
        check("t4_zero_busy", busy, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        #1;
        check("t4_done1", last_done, base);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        #1;
        check("t4_done2", last_done, base + IW'(1));
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        #1;
        check("t4_done3", last_done, base + IW'(2));
        check("t4_idle", busy, 1'b0);

        // randomized traffic (IDs wrap several times)
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0,
                 {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 4096)),
                 $urandom_range(0, 2) != 0,
                 ($urandom_range(0, 2) == 0) && (infl_q.size() > 0));
        end
        drain();

        // reset mid-operation: 2 queued, 1 in flight
        for (int i = 0; i < 3; i++) step(1'b1, 64'(i + 7), 64'(i + 9), 32'd32, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        check("t6_pre_busy", 64'(pend_q.size() * 16 + infl_q.size()), 64'h21);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 64'h5, 64'h6, 32'd12, 1'b1, 1'b0);
        check("t6_tid_restart", obs_tid, IW'(1));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
